pipeline_ex_muldiv: RTL and testbench

Parametrised EX-stage multiply/divide unit for the pipelined MIPS core. It sits beside the ALU in EX and shares the ALU's operand forwarding selects. It runs MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and owns the HI/LO registers. It stalls the pipeline only when a later HI/LO access arrives before the current operation has finished.

---
 rtl/pipeline_ex_muldiv.sv | 219 +++++++++++++++++++++
 tb/tb_pipeline_ex_muldiv.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ex_muldiv.sv
// pipeline_ex_muldiv
// Iterative multiply/divide unit for the EX stage of the pipelined MIPS core.
// Runs MULT/MULTU/DIV/DIVU one bit per cycle (WIDTH cycles per operation),
// owns the HI/LO registers, serves MFHI/MFLO/MTHI/MTLO, and stalls the pipe
// only when a HI/LO-class instruction arrives while an operation is running.
//
// Ports
//   clk                    rising-edge clock
//   reset                  synchronous, active-low
//   start                  HI/LO-class instruction valid in EX this cycle
//   op[2:0]                000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                          100 MFHI, 101 MFLO, 110 MTHI, 111 MTLO
//   ForwardA/ForwardB      operand select: 00 reg file, 01 MEM/WB, 10 EX/MEM, 11 zero
//   EX_dataA/EX_dataB      register-file operands
//   EXMEMdata/MEMWBdata    forwarded results
//   flush                  kill instruction in EX, abort operation in flight
//   busy                   iterative operation in progress
//   ex_stall               combinational stall for IF/ID/EX
//   mf_data                HI/LO value for MFHI/MFLO, zero otherwise
//   HI/LO                  architectural registers
//
// state | meaning
// IDLE  | no operation in progress; accepts ops and MTHI/MTLO writes
// RUN   | iterating, cnt counts WIDTH-1 down to 0; write-back on the cnt==0 edge

module pipeline_ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [1:0]       ForwardA,
  input  logic [1:0]       ForwardB,
  input  logic [WIDTH-1:0] EX_dataA,
  input  logic [WIDTH-1:0] EX_dataB,
  input  logic [WIDTH-1:0] EXMEMdata,
  input  logic [WIDTH-1:0] MEMWBdata,
  input  logic             flush,
  output logic             busy,
  output logic             ex_stall,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             b_zero;
  logic [WIDTH-1:0] opnd;    // multiplicand for MUL, divisor for DIV
  logic [WIDTH-1:0] acc_hi;  // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;  // multiplier bits / dividend-quotient shifter

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             signed_op;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_n;
  logic [WIDTH-1:0]   mul_lo_n;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;

  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_n;
  logic [WIDTH-1:0] div_lo_n;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand forwarding, same selects as the ALU.
  always_comb begin
    case (ForwardA)
      2'b00:   opa = EX_dataA;
      2'b01:   opa = MEMWBdata;
      2'b10:   opa = EXMEMdata;
      default: opa = '0;
    endcase
    case (ForwardB)
      2'b00:   opb = EX_dataB;
      2'b01:   opb = MEMWBdata;
      2'b10:   opb = EXMEMdata;
      default: opb = '0;
    endcase
  end

  // op[0]==0 selects the signed variants (MULT, DIV).
  assign signed_op = ~op[0];
  assign abs_a     = (signed_op && opa[WIDTH-1]) ? -opa : opa;
  assign abs_b     = (signed_op && opb[WIDTH-1]) ? -opb : opb;

  // Shift-add step: add multiplicand when the current multiplier LSB is set,
  // then shift the whole 2W accumulator right by one.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
    prod_raw = {mul_hi_n, mul_lo_n};
    prod_fix = neg_q ? -prod_raw : prod_raw;
  end

  // Restoring-division step. Partial remainder stays below the divisor, so
  // the shifted value fits W+1 bits and the diff MSB is a clean borrow flag.
  always_comb begin
    div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd};
    div_ge   = ~div_diff[WIDTH];
    div_hi_n = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_lo_n = {acc_lo[WIDTH-2:0], div_ge};
    // Divide-by-zero: the algorithm already leaves the magnitude of A as the
    // remainder (sign-restored below), only the quotient needs forcing.
    quot_fix = b_zero ? '1 : (neg_q ? -div_lo_n : div_lo_n);
    rem_fix  = neg_r ? -div_hi_n : div_hi_n;
  end

  assign ex_stall = start & busy & ~flush;

  always_comb begin
    mf_data = '0;
    if (start) begin
      if (op == 3'b100) mf_data = HI;
      else if (op == 3'b101) mf_data = LO;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            if (!op[2]) begin
              state  <= RUN;
              busy   <= 1'b1;
              cnt    <= CNT_TOP;
              is_div <= op[1];
              neg_q  <= signed_op & (opa[WIDTH-1] ^ opb[WIDTH-1]);
              neg_r  <= signed_op & opa[WIDTH-1];
              b_zero <= (opb == '0);
              acc_hi <= '0;
              if (op[1]) begin
                opnd   <= abs_b;
                acc_lo <= abs_a;
              end else begin
                opnd   <= abs_a;
                acc_lo <= abs_b;
              end
            end else if (op == 3'b110) begin
              HI <= opa;
            end else if (op == 3'b111) begin
              LO <= opa;
            end
          end
        end
        RUN: begin
          if (flush) begin
            // Abandon: HI/LO untouched.
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            if (is_div) begin
              acc_hi <= div_hi_n;
              acc_lo <= div_lo_n;
            end else begin
              acc_hi <= mul_hi_n;
              acc_lo <= mul_lo_n;
            end
            if (cnt == '0) begin
              // Last iteration: sign correction folded into write-back.
              state <= IDLE;
              busy  <= 1'b0;
              if (is_div) begin
                HI <= rem_fix;
                LO <= quot_fix;
              end else begin
                HI <= prod_fix[2*WIDTH-1:WIDTH];
                LO <= prod_fix[WIDTH-1:0];
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ex_muldiv.sv
module tb_pipeline_ex_muldiv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // 32-bit instance
  logic        reset, start, flush;
  logic [2:0]  op;
  logic [1:0]  fa, fb;
  logic [31:0] da, db, exmem, memwb;
  logic        busy, ex_stall;
  logic [31:0] mf_data, hi, lo;

  pipeline_ex_muldiv #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .ForwardA(fa), .ForwardB(fb), .EX_dataA(da), .EX_dataB(db),
    .EXMEMdata(exmem), .MEMWBdata(memwb), .flush(flush),
    .busy(busy), .ex_stall(ex_stall), .mf_data(mf_data), .HI(hi), .LO(lo)
  );

  // 8-bit instance
  logic       s8_start;
  logic [2:0] s8_op;
  logic [7:0] s8_a, s8_b;
  logic       s8_busy, s8_stall;
  logic [7:0] s8_mf, s8_hi, s8_lo;

  pipeline_ex_muldiv #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(s8_start), .op(s8_op),
    .ForwardA(2'b00), .ForwardB(2'b00), .EX_dataA(s8_a), .EX_dataB(s8_b),
    .EXMEMdata(8'h00), .MEMWBdata(8'h00), .flush(1'b0),
    .busy(s8_busy), .ex_stall(s8_stall), .mf_data(s8_mf), .HI(s8_hi), .LO(s8_lo)
  );

  // 16-bit instance
  logic        s16_start;
  logic [2:0]  s16_op;
  logic [15:0] s16_a, s16_b;
  logic        s16_busy, s16_stall;
  logic [15:0] s16_mf, s16_hi, s16_lo;

  pipeline_ex_muldiv #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .start(s16_start), .op(s16_op),
    .ForwardA(2'b00), .ForwardB(2'b00), .EX_dataA(s16_a), .EX_dataB(s16_b),
    .EXMEMdata(16'h0000), .MEMWBdata(16'h0000), .flush(1'b0),
    .busy(s16_busy), .ex_stall(s16_stall), .mf_data(s16_mf), .HI(s16_hi), .LO(s16_lo)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait32(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick;
    end
  endtask

  task automatic run32(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    fa = 2'b00; fb = 2'b00; da = a; db = b; op = o; start = 1'b1;
    tick;
    start = 1'b0;
    wait32(n);
    chk({tag, " busy_len"}, 64'(n), 64'd32);
    chk({tag, " hi"}, {32'h0, hi}, {32'h0, ehi});
    chk({tag, " lo"}, {32'h0, lo}, {32'h0, elo});
  endtask

  task automatic run8(input string tag, input logic [2:0] o, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] ehi, input logic [7:0] elo);
    int n;
    s8_op = o; s8_a = a; s8_b = b; s8_start = 1'b1;
    tick;
    s8_start = 1'b0;
    n = 0;
    while (s8_busy === 1'b1 && n < 100) begin
      n++;
      tick;
    end
    chk({tag, " busy_len"}, 64'(n), 64'd8);
    chk({tag, " hi"}, {56'h0, s8_hi}, {56'h0, ehi});
    chk({tag, " lo"}, {56'h0, s8_lo}, {56'h0, elo});
  endtask

  task automatic run16(input string tag, input logic [2:0] o, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] ehi, input logic [15:0] elo);
    int n;
    s16_op = o; s16_a = a; s16_b = b; s16_start = 1'b1;
    tick;
    s16_start = 1'b0;
    n = 0;
    while (s16_busy === 1'b1 && n < 100) begin
      n++;
      tick;
    end
    chk({tag, " busy_len"}, 64'(n), 64'd16);
    chk({tag, " hi"}, {48'h0, s16_hi}, {48'h0, ehi});
    chk({tag, " lo"}, {48'h0, s16_lo}, {48'h0, elo});
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b000;
    fa = 2'b00; fb = 2'b00; da = '0; db = '0; exmem = '0; memwb = '0;
    s8_start = 1'b0; s8_op = 3'b000; s8_a = '0; s8_b = '0;
    s16_start = 1'b0; s16_op = 3'b000; s16_a = '0; s16_b = '0;
    tick;
    tick;
    chk("reset hi", {32'h0, hi}, 64'h0);
    chk("reset lo", {32'h0, lo}, 64'h0);
    chk("reset busy", {63'h0, busy}, 64'h0);
    chk("reset stall", {63'h0, ex_stall}, 64'h0);
    chk("reset mf", {32'h0, mf_data}, 64'h0);
    reset = 1'b1;
    tick;

    // Multiply / divide directed vectors
    run32("mult -3*5", 3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    op = 3'b101; start = 1'b0; #1;
    chk("mf gated by start", {32'h0, mf_data}, 64'h0);
    start = 1'b1; #1;
    chk("mflo after mult", {32'h0, mf_data}, 64'hFFFFFFF1);
    start = 1'b0;
    run32("multu", 3'b001, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1);
    run32("div -7/2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run32("divu 7/0", 3'b011, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
    run32("div -7/0", 3'b010, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run32("div minneg/-1", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

    // Stall behind a running multiply
    fa = 2'b00; fb = 2'b00; da = 32'd6; db = 32'd7; op = 3'b001; start = 1'b1;
    tick;
    op = 3'b000; #1;
    chk("stall second mult", {63'h0, ex_stall}, 64'h1);
    start = 1'b0;
    tick; tick; tick;
    op = 3'b101; start = 1'b1; #1;
    n = 0;
    while (ex_stall === 1'b1 && n < 100) begin
      n++;
      tick;
    end
    chk("mflo stall len", 64'(n), 64'd29);
    chk("mflo stalled data", {32'h0, mf_data}, 64'd42);
    chk("busy after stall", {63'h0, busy}, 64'h0);
    start = 1'b0;

    // Forwarding
    fa = 2'b10; exmem = 32'd12; fb = 2'b01; memwb = 32'd3;
    da = 32'd999; db = 32'd888; op = 3'b001; start = 1'b1;
    tick;
    start = 1'b0; fa = 2'b00; fb = 2'b00;
    wait32(n);
    chk("fwd multu lo", {32'h0, lo}, 64'd36);
    chk("fwd multu hi", {32'h0, hi}, 64'd0);

    // MTHI / MTLO
    da = 32'h1234; op = 3'b110; start = 1'b1; #1;
    chk("mf zero on mthi", {32'h0, mf_data}, 64'h0);
    tick;
    op = 3'b100; #1;
    chk("mfhi after mthi", {32'h0, mf_data}, 64'h1234);
    op = 3'b110; fa = 2'b11;
    tick;
    chk("mthi zero fwd", {32'h0, hi}, 64'h0);
    op = 3'b111; fa = 2'b00; da = 32'hABCD;
    tick;
    op = 3'b101; #1;
    chk("mflo after mtlo", {32'h0, mf_data}, 64'hABCD);
    start = 1'b0;

    // Flush mid-divide
    da = 32'd100; db = 32'd7; op = 3'b010; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    op = 3'b101; start = 1'b1; flush = 1'b1; #1;
    chk("stall masked by flush", {63'h0, ex_stall}, 64'h0);
    start = 1'b0;
    tick;
    flush = 1'b0;
    chk("flush busy", {63'h0, busy}, 64'h0);
    chk("flush hi kept", {32'h0, hi}, 64'h0);
    chk("flush lo kept", {32'h0, lo}, 64'hABCD);
    run32("post-flush mult", 3'b000, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h0, 32'd6);

    // Flush together with start in IDLE: ignored
    da = 32'd3; db = 32'd3; op = 3'b000; start = 1'b1; flush = 1'b1;
    tick;
    start = 1'b0; flush = 1'b0;
    chk("flush+start ignored", {63'h0, busy}, 64'h0);

    // Reset during a multiply
    da = 32'd3; db = 32'd4; op = 3'b000; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk("rst mid hi", {32'h0, hi}, 64'h0);
    chk("rst mid lo", {32'h0, lo}, 64'h0);
    chk("rst mid busy", {63'h0, busy}, 64'h0);
    repeat (40) tick;
    chk("no late wb hi", {32'h0, hi}, 64'h0);
    chk("no late wb lo", {32'h0, lo}, 64'h0);

    // Narrow widths
    run8("w8 mult -3*5", 3'b000, 8'hFD, 8'h05, 8'hFF, 8'hF1);
    run8("w8 multu 200*200", 3'b001, 8'd200, 8'd200, 8'h9C, 8'h40);
    run8("w8 div 100/-7", 3'b010, 8'd100, 8'hF9, 8'h02, 8'hF2);
    run8("w8 divu 200/7", 3'b011, 8'd200, 8'd7, 8'h04, 8'h1C);
    run8("w8 div -128/-1", 3'b010, 8'h80, 8'hFF, 8'h00, 8'h80);
    run16("w16 mult -300*200", 3'b000, 16'hFED4, 16'd200, 16'hFFFF, 16'h15A0);
    run16("w16 div -1000/33", 3'b010, 16'hFC18, 16'd33, 16'hFFF6, 16'hFFE2);
    run16("w16 divu 65535/0", 3'b011, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
